// File: rtl/otter_trap_ctrl_pkg.sv
// Shared encodings for the Otter trap sequencer: FSM states, PC-select codes,
// CSR operation codes and mcause selectors used by otter_csr.
package otter_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        TRAP_ST_INIT = 2'd0,
        TRAP_ST_RUN  = 2'd1,
        TRAP_ST_TRAP = 2'd2,
        TRAP_ST_WFI  = 2'd3
    } trap_st_t;

    localparam logic [1:0] PC_SEL_NEXT  = 2'd0;
    localparam logic [1:0] PC_SEL_MTVEC = 2'd1;
    localparam logic [1:0] PC_SEL_MEPC  = 2'd2;
    localparam logic [1:0] PC_SEL_HOLD  = 2'd3;

    // CSR_OP_WFI doubles as the no-operation code for otter_csr.
    localparam logic [2:0] CSR_OP_RESET  = 3'd0;
    localparam logic [2:0] CSR_OP_WRITE  = 3'd1;
    localparam logic [2:0] CSR_OP_TRAP   = 3'd2;
    localparam logic [2:0] CSR_OP_ECALL  = 3'd3;
    localparam logic [2:0] CSR_OP_EBREAK = 3'd4;
    localparam logic [2:0] CSR_OP_MRET   = 3'd5;
    localparam logic [2:0] CSR_OP_INTRPT = 3'd6;
    localparam logic [2:0] CSR_OP_WFI    = 3'd7;

    localparam logic [2:0] MCAUSE_SEL_NONE                = 3'd0;
    localparam logic [2:0] MCAUSE_SEL_INSTR_ADDR_MISALIGN = 3'd1;
    localparam logic [2:0] MCAUSE_SEL_ILLEGAL_INSTR       = 3'd2;
    localparam logic [2:0] MCAUSE_SEL_BREAKPOINT          = 3'd3;
    localparam logic [2:0] MCAUSE_SEL_ECALL               = 3'd4;
    localparam logic [2:0] MCAUSE_SEL_LOAD_ADDR_MISALIGN  = 3'd5;
    localparam logic [2:0] MCAUSE_SEL_STORE_ADDR_MISALIGN = 3'd6;
    localparam logic [2:0] MCAUSE_SEL_INTRPT              = 3'd7;

endpackage

// File: rtl/otter_trap_prio.sv
// Fixed-priority selection of the commit-stage event: trap flag, wfi flag,
// the CSR op to issue and the mcause selector for traps.
module otter_trap_prio
    import otter_trap_ctrl_pkg::*;
(
    input  logic       intrpt_vld,
    input  logic       instr_misalign,
    input  logic       illegal_instr,
    input  logic       ebreak,
    input  logic       ecall,
    input  logic       load_misalign,
    input  logic       store_misalign,
    input  logic       mret,
    input  logic       wfi,
    input  logic       csr_instr,
    output logic       trap_vld,
    output logic       wfi_vld,
    output logic [2:0] op,
    output logic [2:0] mcause
);

    always_comb begin
        trap_vld = 1'b1;
        wfi_vld  = 1'b0;
        op       = CSR_OP_TRAP;
        mcause   = MCAUSE_SEL_NONE;
        if (intrpt_vld) begin
            op     = CSR_OP_INTRPT;
            mcause = MCAUSE_SEL_INTRPT;
        end else if (instr_misalign) begin
            mcause = MCAUSE_SEL_INSTR_ADDR_MISALIGN;
        end else if (illegal_instr) begin
            mcause = MCAUSE_SEL_ILLEGAL_INSTR;
        end else if (ebreak) begin
            op     = CSR_OP_EBREAK;
            mcause = MCAUSE_SEL_BREAKPOINT;
        end else if (ecall) begin
            op     = CSR_OP_ECALL;
            mcause = MCAUSE_SEL_ECALL;
        end else if (load_misalign) begin
            mcause = MCAUSE_SEL_LOAD_ADDR_MISALIGN;
        end else if (store_misalign) begin
            mcause = MCAUSE_SEL_STORE_ADDR_MISALIGN;
        end else begin
            // Non-trap instructions; an empty boundary also maps to the nop.
            trap_vld = 1'b0;
            if (mret) begin
                op = CSR_OP_MRET;
            end else if (wfi) begin
                op      = CSR_OP_WFI;
                wfi_vld = 1'b1;
            end else if (csr_instr) begin
                op = CSR_OP_WRITE;
            end else begin
                op = CSR_OP_WFI;
            end
        end
    end

endmodule

// File: rtl/otter_trap_ctrl.sv
// Trap/interrupt sequencer between commit logic and otter_csr.
// Optional WFI sleep state is enabled by defining OTTER_TRAP_WFI_EN.
module otter_trap_ctrl
    import otter_trap_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_vld,
    input  logic [31:0] pc,
    input  logic [31:0] bad_addr,
    input  logic        instr_misalign,
    input  logic        illegal_instr,
    input  logic        load_misalign,
    input  logic        store_misalign,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        wfi,
    input  logic        csr_instr,
    input  logic        intrpt_vld,
    input  logic        wake,
    output logic [2:0]  csr_op_sel,
    output logic [2:0]  csr_mcause_sel,
    output logic        csr_w_en,
    output logic [31:0] csr_pc_addr,
    output logic [31:0] csr_mtval,
    output logic [1:0]  pc_sel,
    output logic        stall,
    output logic        flush
);

    trap_st_t    state, next_state;
    logic [3:0]  reset_cnt;
    logic [2:0]  trap_op;
    logic [2:0]  trap_cause;
    logic [31:0] mepc_val;
    logic [31:0] mtval_val;
    logic        trap_vld, wfi_vld;
    logic [2:0]  prio_op, prio_cause;

    otter_trap_prio u_prio (
        .intrpt_vld     (intrpt_vld),
        .instr_misalign (instr_misalign),
        .illegal_instr  (illegal_instr),
        .ebreak         (ebreak),
        .ecall          (ecall),
        .load_misalign  (load_misalign),
        .store_misalign (store_misalign),
        .mret           (mret),
        .wfi            (wfi),
        .csr_instr      (csr_instr),
        .trap_vld       (trap_vld),
        .wfi_vld        (wfi_vld),
        .op             (prio_op),
        .mcause         (prio_cause)
    );

    wire take_trap = (state == TRAP_ST_RUN) && instr_vld && trap_vld;

`ifdef OTTER_TRAP_WFI_EN
    logic [31:0] wfi_pc;
    wire enter_wfi   = (state == TRAP_ST_RUN) && instr_vld && wfi_vld;
    wire wake_intrpt = (state == TRAP_ST_WFI) && wake && intrpt_vld;

    always_ff @(posedge clk) begin
        if (enter_wfi) wfi_pc <= pc;
    end
`else
    logic unused_wake;
    assign unused_wake = wake ^ wfi_vld;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= TRAP_ST_INIT;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TRAP_ST_INIT: if (reset_cnt <= 4'd1) next_state = TRAP_ST_RUN;
            TRAP_ST_RUN: begin
                if (take_trap) next_state = TRAP_ST_TRAP;
`ifdef OTTER_TRAP_WFI_EN
                else if (enter_wfi) next_state = TRAP_ST_WFI;
`endif
            end
            TRAP_ST_TRAP: next_state = TRAP_ST_RUN;
`ifdef OTTER_TRAP_WFI_EN
            TRAP_ST_WFI: if (wake) next_state = intrpt_vld ? TRAP_ST_TRAP : TRAP_ST_RUN;
`endif
            default: next_state = TRAP_ST_INIT;
        endcase
    end

    // rst overrides the state decode so a pending trap op is never issued.
    always_comb begin
        csr_op_sel = CSR_OP_WFI;
        csr_w_en   = 1'b0;
        pc_sel     = PC_SEL_NEXT;
        stall      = 1'b0;
        flush      = 1'b0;
        if (rst || state == TRAP_ST_INIT) begin
            csr_op_sel = CSR_OP_RESET;
            pc_sel     = PC_SEL_HOLD;
            stall      = 1'b1;
        end else if (state == TRAP_ST_TRAP) begin
            csr_op_sel = trap_op;
            pc_sel     = PC_SEL_MTVEC;
            stall      = 1'b1;
        end else if (state == TRAP_ST_WFI) begin
            pc_sel = PC_SEL_HOLD;
            stall  = 1'b1;
        end else if (instr_vld) begin
            if (trap_vld) begin
                flush = 1'b1;
            end else begin
                csr_op_sel = prio_op;
                csr_w_en   = (prio_op == CSR_OP_WRITE);
                if (prio_op == CSR_OP_MRET) begin
                    pc_sel = PC_SEL_MEPC;
                    flush  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reset_cnt  <= 4'(RESET_CYCLES);
            trap_op    <= CSR_OP_RESET;
            trap_cause <= MCAUSE_SEL_NONE;
            mepc_val   <= 32'd0;
            mtval_val  <= 32'd0;
        end else begin
            if (state == TRAP_ST_INIT && reset_cnt > 4'd1) reset_cnt <= reset_cnt - 4'd1;
            if (take_trap) begin
                trap_op    <= prio_op;
                trap_cause <= prio_cause;
                mepc_val   <= pc;
                if (!intrpt_vld) mtval_val <= bad_addr;
            end
`ifdef OTTER_TRAP_WFI_EN
            if (wake_intrpt) begin
                trap_op    <= CSR_OP_INTRPT;
                trap_cause <= MCAUSE_SEL_INTRPT;
                mepc_val   <= wfi_pc + 32'd4;
            end
`endif
        end
    end

    assign csr_mcause_sel = trap_cause;
    assign csr_pc_addr    = mepc_val;
    assign csr_mtval      = mtval_val;

endmodule

// File: tb/tb_otter_trap_ctrl.sv
// Directed + randomized bench for otter_trap_ctrl with an event-level model.
// Exercises the WFI sleep path only when OTTER_TRAP_WFI_EN is defined.
module tb_otter_trap_ctrl;
    import otter_trap_ctrl_pkg::*;

    localparam int RC = 2;
`ifdef OTTER_TRAP_WFI_EN
    localparam bit WFI_EN = 1'b1;
`else
    localparam bit WFI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, instr_vld, instr_misalign, illegal_instr, load_misalign, store_misalign;
    logic ecall, ebreak, mret, wfi, csr_instr, intrpt_vld, wake;
    logic [31:0] pc, bad_addr;
    logic [2:0]  csr_op_sel, csr_mcause_sel;
    logic        csr_w_en, stall, flush;
    logic [31:0] csr_pc_addr, csr_mtval;
    logic [1:0]  pc_sel;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: high-level machine status, not the RTL encoding.
    bit          m_in_init, m_in_trap, m_in_wfi;
    int          m_rst_left;
    logic [2:0]  m_trap_op, m_mcause;
    logic [31:0] m_mepc, m_mtval, m_wfi_pc;

    logic [2:0] op_tab [7] = '{CSR_OP_INTRPT, CSR_OP_TRAP, CSR_OP_TRAP, CSR_OP_EBREAK,
                               CSR_OP_ECALL, CSR_OP_TRAP, CSR_OP_TRAP};
    logic [2:0] mc_tab [7] = '{MCAUSE_SEL_INTRPT, MCAUSE_SEL_INSTR_ADDR_MISALIGN,
                               MCAUSE_SEL_ILLEGAL_INSTR, MCAUSE_SEL_BREAKPOINT,
                               MCAUSE_SEL_ECALL, MCAUSE_SEL_LOAD_ADDR_MISALIGN,
                               MCAUSE_SEL_STORE_ADDR_MISALIGN};

    otter_trap_ctrl #(.RESET_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .instr_vld(instr_vld), .pc(pc), .bad_addr(bad_addr),
        .instr_misalign(instr_misalign), .illegal_instr(illegal_instr),
        .load_misalign(load_misalign), .store_misalign(store_misalign),
        .ecall(ecall), .ebreak(ebreak), .mret(mret), .wfi(wfi), .csr_instr(csr_instr),
        .intrpt_vld(intrpt_vld), .wake(wake),
        .csr_op_sel(csr_op_sel), .csr_mcause_sel(csr_mcause_sel), .csr_w_en(csr_w_en),
        .csr_pc_addr(csr_pc_addr), .csr_mtval(csr_mtval), .pc_sel(pc_sel),
        .stall(stall), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int first_event();
        bit ev [10];
        ev = '{intrpt_vld, instr_misalign, illegal_instr, ebreak, ecall,
               load_misalign, store_misalign, mret, wfi, csr_instr};
        for (int i = 0; i < 10; i++) if (ev[i]) return i;
        return 10;
    endfunction

    task automatic clear_in();
        instr_vld = 0; instr_misalign = 0; illegal_instr = 0; load_misalign = 0;
        store_misalign = 0; ecall = 0; ebreak = 0; mret = 0; wfi = 0; csr_instr = 0;
        intrpt_vld = 0; wake = 0;
    endtask

    task automatic check_all();
        logic [2:0] e_op; logic [1:0] e_sel; logic e_stall, e_flush, e_wen;
        int k;
        e_op = CSR_OP_WFI; e_sel = PC_SEL_NEXT; e_stall = 0; e_flush = 0; e_wen = 0;
        k = first_event();
        if (rst || m_in_init) begin
            e_op = CSR_OP_RESET; e_sel = PC_SEL_HOLD; e_stall = 1;
        end else if (m_in_trap) begin
            e_op = m_trap_op; e_sel = PC_SEL_MTVEC; e_stall = 1;
        end else if (m_in_wfi) begin
            e_sel = PC_SEL_HOLD; e_stall = 1;
        end else if (instr_vld) begin
            if (k < 7) e_flush = 1;
            else if (k == 7) begin e_op = CSR_OP_MRET; e_sel = PC_SEL_MEPC; e_flush = 1; end
            else if (k == 9) begin e_op = CSR_OP_WRITE; e_wen = 1; end
        end
        chk("op_sel", 32'(csr_op_sel), 32'(e_op));
        chk("mcause", 32'(csr_mcause_sel), 32'(m_mcause));
        chk("w_en", 32'(csr_w_en), 32'(e_wen));
        chk("pc_addr", csr_pc_addr, m_mepc);
        chk("mtval", csr_mtval, m_mtval);
        chk("pc_sel", 32'(pc_sel), 32'(e_sel));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(e_flush));
    endtask

    task automatic model_update();
        int k;
        k = first_event();
        if (rst) begin
            m_in_init = 1; m_rst_left = RC; m_in_trap = 0; m_in_wfi = 0;
            m_mcause = MCAUSE_SEL_NONE; m_mepc = 0; m_mtval = 0;
        end else if (m_in_init) begin
            if (m_rst_left <= 1) m_in_init = 0;
            else m_rst_left--;
        end else if (m_in_trap) begin
            m_in_trap = 0;
        end else if (m_in_wfi) begin
            if (wake) begin
                m_in_wfi = 0;
                if (intrpt_vld) begin
                    m_in_trap = 1; m_trap_op = CSR_OP_INTRPT;
                    m_mcause = MCAUSE_SEL_INTRPT; m_mepc = m_wfi_pc + 4;
                end
            end
        end else if (instr_vld && k < 7) begin
            m_in_trap = 1; m_trap_op = op_tab[k]; m_mcause = mc_tab[k]; m_mepc = pc;
            if (k != 0) m_mtval = bad_addr;
        end else if (instr_vld && k == 8 && WFI_EN) begin
            m_in_wfi = 1; m_wfi_pc = pc;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1; pc = 0; bad_addr = 0;
        @(posedge clk); model_update(); #1;
        cyc(); cyc();
        // Reset released: RESET_CYCLES more init cycles.
        rst = 0;
        #1 chk("init_hold1", 32'(csr_op_sel), 32'(CSR_OP_RESET));
        cyc();
        #1 chk("init_hold2", 32'(stall), 32'd1);
        cyc();
        #1 chk("run_stall", 32'(stall), 32'd0);
        cyc();

        // ECALL trap
        instr_vld = 1; ecall = 1; pc = 32'h100; bad_addr = 32'hdead;
        #1 chk("ecall_flush", 32'(flush), 32'd1);
        cyc(); clear_in();
        #1 chk("ecall_op", 32'(csr_op_sel), 32'(CSR_OP_ECALL));
        chk("ecall_mepc", csr_pc_addr, 32'h100);
        chk("ecall_pcsel", 32'(pc_sel), 32'(PC_SEL_MTVEC));
        cyc();
        #1 chk("ecall_ret", 32'(stall), 32'd0);
        cyc();

        // Interrupt beats illegal instruction, mtval untouched
        instr_vld = 1; intrpt_vld = 1; illegal_instr = 1; pc = 32'h200; bad_addr = 32'hbeef;
        cyc(); clear_in();
        #1 chk("intr_op", 32'(csr_op_sel), 32'(CSR_OP_INTRPT));
        chk("intr_mepc", csr_pc_addr, 32'h200);
        chk("intr_mtval", csr_mtval, 32'hdead);
        cyc(); cyc();

        // Load misalign
        instr_vld = 1; load_misalign = 1; pc = 32'h400; bad_addr = 32'h1003;
        cyc(); clear_in();
        #1 chk("ld_op", 32'(csr_op_sel), 32'(CSR_OP_TRAP));
        chk("ld_cause", 32'(csr_mcause_sel), 32'(MCAUSE_SEL_LOAD_ADDR_MISALIGN));
        chk("ld_mtval", csr_mtval, 32'h1003);
        cyc(); cyc();

        // MRET and CSR write are zero latency
        instr_vld = 1; mret = 1;
        #1 chk("mret_op", 32'(csr_op_sel), 32'(CSR_OP_MRET));
        chk("mret_pcsel", 32'(pc_sel), 32'(PC_SEL_MEPC));
        cyc(); clear_in();
        instr_vld = 1; csr_instr = 1;
        #1 chk("csrw_wen", 32'(csr_w_en), 32'd1);
        cyc(); clear_in();
        intrpt_vld = 1;
        #1 chk("intr_no_boundary", 32'(flush), 32'd0);
        cyc(); clear_in();

        // WFI
        instr_vld = 1; wfi = 1; pc = 32'h300;
        cyc(); clear_in();
        if (WFI_EN) begin
            for (int i = 0; i < 10; i++) begin
                #1 chk("wfi_stall", 32'(stall), 32'd1);
                cyc();
            end
            wake = 1; intrpt_vld = 1;
            #1 chk("wfi_wake_stall", 32'(stall), 32'd1);
            cyc(); clear_in();
            #1 chk("wfi_intr_op", 32'(csr_op_sel), 32'(CSR_OP_INTRPT));
            chk("wfi_mepc", csr_pc_addr, 32'h304);
            cyc();
        end else begin
            #1 chk("wfi_nop_stall", 32'(stall), 32'd0);
            cyc();
        end
        cyc();

        // Reset during TRAP discards the trap op
        instr_vld = 1; ebreak = 1; pc = 32'h500;
        cyc(); clear_in();
        rst = 1;
        #1 chk("rst_trap_op", 32'(csr_op_sel), 32'(CSR_OP_RESET));
        cyc();
        rst = 0;
        #1 chk("rst_trap_init", 32'(csr_op_sel), 32'(CSR_OP_RESET));
        chk("rst_trap_mepc", csr_pc_addr, 32'h0);
        cyc(); cyc(); cyc();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(59) == 0);
            instr_vld      = ($urandom_range(3) != 0);
            intrpt_vld     = ($urandom_range(9) == 0);
            instr_misalign = ($urandom_range(11) == 0);
            illegal_instr  = ($urandom_range(11) == 0);
            ebreak         = ($urandom_range(11) == 0);
            ecall          = ($urandom_range(11) == 0);
            load_misalign  = ($urandom_range(11) == 0);
            store_misalign = ($urandom_range(11) == 0);
            mret           = ($urandom_range(7) == 0);
            wfi            = ($urandom_range(9) == 0);
            csr_instr      = ($urandom_range(3) == 0);
            wake           = ($urandom_range(5) == 0);
            pc             = $urandom & 32'hffff_fffc;
            bad_addr       = $urandom;
            cyc();
        end
        rst = 0; clear_in();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_trap_ctrl.md
# otter_trap_ctrl

Trap and interrupt sequencer for the Otter MCU machine-mode CSR file. It collects commit-stage events: exceptions, ECALL/EBREAK, MRET, WFI, CSR instructions and the CSR file's `intrpt_vld`. Each instruction boundary it picks one event by fixed priority and drives the CSR file's `op_sel`, `mcause_sel`, `w_en`, `pc_addr` and `mtval_trap_addr`, plus the PC-select, stall and flush controls for the fetch path. It sits between the decoder/commit logic and `otter_csr`.

## Interface
Parameters:
- `RESET_CYCLES`, 1: number of cycles the CSR reset op is held after `rst` deasserts (range 1–15).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `instr_vld` in 1: an instruction is at the commit boundary this cycle.
- `pc` in 32: PC of the committing instruction.
- `bad_addr` in 32: faulting address or instruction word for the current exception.
- `instr_misalign`, `illegal_instr`, `load_misalign`, `store_misalign` in 1 each: exception flags.
- `ecall`, `ebreak`, `mret`, `wfi`, `csr_instr` in 1 each: decoded instruction class.
- `intrpt_vld` in 1: interrupt enabled and pending, from the CSR file.
- `wake` in 1: `|(mie & mip)`, regardless of `mstatus.MIE`.
- `csr_op_sel` out 3: CSR operation, using the `CSR_OP_*` codes.
- `csr_mcause_sel` out 3: exception cause, using the `MCAUSE_SEL_*` codes.
- `csr_w_en` out 1: CSR write enable.
- `csr_pc_addr` out 32: value written to `mepc`.
- `csr_mtval` out 32: value written to `mtval`.
- `pc_sel` out 2: next-PC source, `PC_SEL_NEXT` / `MTVEC` / `MEPC` / `HOLD`.
- `stall` out 1: freeze fetch and commit.
- `flush` out 1: kill the in-flight instruction.

## Operation
- FSM states: `INIT`, `RUN`, `TRAP`, `WFI`.
- `INIT`:
  - `csr_op_sel=CSR_OP_RESET`, `stall=1`, `pc_sel=HOLD`.
  - Held while `rst` is high, then for `RESET_CYCLES` more cycles (down-counter), then → `RUN`.
- `RUN`: when `instr_vld` is high, select the highest-priority event, in this order:
  1. `intrpt_vld`
  2. `instr_misalign`
  3. `illegal_instr`
  4. `ebreak`
  5. `ecall`
  6. `load_misalign`
  7. `store_misalign`
  8. `mret`
  9. `wfi`
  10. `csr_instr`
- Events 1–7 (traps):
  - Latch cause into the op/mcause registers, `pc` → `csr_pc_addr`, `bad_addr` → `csr_mtval` (interrupt: mtval unchanged).
  - Assert `flush` the same cycle; go to `TRAP`.
- `TRAP`, exactly one cycle:
  - Drive the latched op: `CSR_OP_INTRPT`, `CSR_OP_EBREAK`, `CSR_OP_ECALL` or `CSR_OP_TRAP` plus `mcause_sel`.
  - `pc_sel=MTVEC`, `stall=1`; then → `RUN`.
- `mret` in `RUN`, same cycle: `csr_op_sel=CSR_OP_MRET`, `pc_sel=MEPC`, `flush=1`; stay in `RUN`.
- `csr_instr` with no higher event, same cycle: `csr_op_sel=CSR_OP_WRITE`, `csr_w_en=1`, `pc_sel=NEXT`.
- `wfi`: see Configuration.
- Idle (`instr_vld=0`): `csr_op_sel=CSR_OP_WFI` (nop), `pc_sel=NEXT`, `stall=0`, `flush=0`.
- `intrpt_vld` without `instr_vld` is ignored; interrupts are taken only at a boundary.
- `csr_w_en` is high only when `csr_op_sel=CSR_OP_WRITE`.

## Timing
- Reset values:
  - state `INIT`, counter `RESET_CYCLES`.
  - `csr_op_sel=CSR_OP_RESET`, `csr_mcause_sel=0`, `csr_w_en=0`.
  - `csr_pc_addr=0`, `csr_mtval=0`.
  - `pc_sel=HOLD`, `stall=1`, `flush=0`.
- Trap latency: event at cycle N; CSR updated at the N+1 edge (`TRAP` state); fetch from `mtvec` at N+2.
- MRET and CSR write: zero latency; the CSR updates at the edge ending the commit cycle.
- `rst` asserted in any state (`TRAP`, `WFI`) → `INIT` next cycle. A latched trap is discarded and no CSR trap op is issued.
- `csr_pc_addr` and `csr_mtval` are registers. They are updated only on trap entry (or WFI wake by interrupt) and hold otherwise.

## Configuration
`OTTER_TRAP_WFI_EN`:
- Defined:
  - `wfi` → `WFI` state with `stall=1`, `pc_sel=HOLD`, `csr_op_sel=CSR_OP_WFI`; the wfi PC is latched.
  - Wake on `wake`:
    - if `intrpt_vld` is also high → `TRAP` with `CSR_OP_INTRPT` and `csr_pc_addr = latched PC + 4`;
    - else → `RUN` with `pc_sel=NEXT` for one cycle.
  - Wake is evaluated the cycle after entry at the earliest.
- Undefined: `wfi` is a nop that emits `CSR_OP_WFI` with `pc_sel=NEXT`; the `WFI` state and its latch are not compiled.

## Structure
- Add to `otter_defines.vh`: `PC_SEL_NEXT=0`, `PC_SEL_MTVEC=1`, `PC_SEL_MEPC=2`, `PC_SEL_HOLD=3`, and `TRAP_ST_INIT/RUN/TRAP/WFI`.
- `CSR_OP_*` and `MCAUSE_SEL_*` are reused from the same header.
- One sub-module, `otter_trap_prio`: combinational priority encoder returning event valid, the CSR op and `mcause_sel`.

## Test plan
- `rst` for 3 cycles, `RESET_CYCLES=2` → `CSR_OP_RESET` for 5 cycles, then `RUN`, `stall=0`.
- `instr_vld`, `ecall`, `pc=0x100` → same cycle `flush=1`; next cycle `CSR_OP_ECALL`, `csr_pc_addr=0x100`, `pc_sel=MTVEC`; then `RUN`.
- `instr_vld`, `intrpt_vld`, `illegal_instr`, `pc=0x200` → `CSR_OP_INTRPT`, `csr_pc_addr=0x200`, `csr_mtval` unchanged.
- `instr_vld`, `load_misalign`, `bad_addr=0x1003` → `CSR_OP_TRAP`, `MCAUSE_SEL_LOAD_ADDR_MISALIGN`, `csr_mtval=0x1003`.
- With `OTTER_TRAP_WFI_EN`: `wfi` at `pc=0x300`, 10 idle cycles, then `wake` with `intrpt_vld` → `stall` high throughout, then `CSR_OP_INTRPT`, `csr_pc_addr=0x304`.
- `rst` asserted during `TRAP` → next cycle `INIT`, `CSR_OP_RESET`, no trap op issued.
